test_status_device: RTL

- Memory-mapped test-result responder on the CPU data bus: the program writes its pass/fail verdict to a "tohost" register, and the block halts the core and reports the result to an external host/bench.
- Provides a free-running cycle counter and a watchdog that declares timeout if no verdict arrives.
- Sits in top next to RAM on the data bus, so simulation and FPGA runs report results without a bench snooping the instruction bus.

---
 rtl/test_status_device_pkg.sv | 37 +++
 rtl/test_status_device_sat_counter.sv | 31 +++
 rtl/test_status_device.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/test_status_device_pkg.sv
// Shared constants for the test-status responder: FSM states, status
// encodings, register offsets, default base address and assertion text.
package test_status_device_pkg;

  typedef enum logic [2:0] {
    S_RUN     = 3'd0,
    S_PASS    = 3'd1,
    S_FAIL    = 3'd2,
    S_TIMEOUT = 3'd3,
    S_ACKED   = 3'd4
  } state_e;

  localparam logic [1:0] STAT_RUN     = 2'b00;
  localparam logic [1:0] STAT_PASS    = 2'b01;
  localparam logic [1:0] STAT_FAIL    = 2'b10;
  localparam logic [1:0] STAT_TIMEOUT = 2'b11;

  localparam logic [31:0] REG_TOHOST = 32'd0;
  localparam logic [31:0] REG_CYCLE  = 32'd4;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hFFFF_FFF0;

  localparam string MSG_DONE_NO_HALT = "test_status_device: done raised without cpuHalt";
  localparam string MSG_RUN_HALTED   = "test_status_device: cpuHalt raised while status is RUN";

  // Status code reported for a terminal state; ACKED has no code of its own
  // and callers keep the previously reported value instead.
  function automatic logic [1:0] state_to_status(input state_e s);
    case (s)
      S_PASS:    return STAT_PASS;
      S_FAIL:    return STAT_FAIL;
      S_TIMEOUT: return STAT_TIMEOUT;
      default:   return STAT_RUN;
    endcase
  endfunction

endpackage

// File: rtl/test_status_device_sat_counter.sv
// Up-counter with enable and synchronous clear that sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear beats enable; hold once every bit is set.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/test_status_device.sv
// Memory-mapped tohost responder: takes the program's verdict, halts the
// core, reports to the host, and times out runs that never report.
module test_status_device
  import test_status_device_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = DEFAULT_BASE_ADDR,
  parameter int          TIMEOUT_CYCLES = 50000,
  parameter int          CNT_W          = 32
) (
  input  logic        sysClk,
  input  logic        sysRes,
  input  logic [31:0] busAddr,
  input  logic [31:0] busWrData,
  input  logic        busWE,
  output logic [31:0] busRdData,
  output logic        busSel,
  output logic        cpuHalt,
  output logic        done,
  output logic [1:0]  status,
  output logic [30:0] failCode,
  input  logic        hostAck
);

  localparam logic [31:0] TOHOST_ADDR = BASE_ADDR + REG_TOHOST;
  localparam logic [31:0] CYCLE_ADDR  = BASE_ADDR + REG_CYCLE;
  // Counter value at which the watchdog fires; unused when disabled.
  localparam logic [CNT_W-1:0] WD_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  state_e       state_q, state_d;
  logic [30:0]  fail_code_q, fail_code_d;
  logic [1:0]   status_q, status_d;
  logic         done_q, done_d;
  logic         halt_q, halt_d;
  logic [31:0]  rd_data_q, rd_data_d;
  logic [CNT_W-1:0] cycle_cnt;
  logic [31:0]  cycle_ext;

  logic hit_tohost, hit_cycle;
  logic wr_pass, wr_fail, wd_fire;

  assign hit_tohost = (busAddr == TOHOST_ADDR);
  assign hit_cycle  = (busAddr == CYCLE_ADDR);
  assign busSel     = hit_tohost | hit_cycle;

  // d==1 is PASS; odd values with a nonzero test number are FAIL; zero and
  // even values are left alone.
  assign wr_pass = busWE && hit_tohost && (busWrData == 32'd1);
  assign wr_fail = busWE && hit_tohost && busWrData[0] && (busWrData[31:1] != '0);
  assign wd_fire = (TIMEOUT_CYCLES != 0) && (cycle_cnt == WD_LAST);

  // Cycle counter only runs while the test is running.
  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk (sysClk),
    .rst (sysRes),
    .clr (1'b0),
    .en  (state_q == S_RUN),
    .cnt (cycle_cnt)
  );

  // Zero-extend the counter for the CYCLE register read.
  always_comb begin
    cycle_ext = '0;
    cycle_ext[CNT_W-1:0] = cycle_cnt;
  end

  // Verdict FSM: a valid write beats a same-cycle watchdog expiry.
  always_comb begin
    state_d     = state_q;
    fail_code_d = fail_code_q;
    case (state_q)
      S_RUN: begin
        if (wr_pass) begin
          state_d = S_PASS;
        end else if (wr_fail) begin
          state_d     = S_FAIL;
          fail_code_d = busWrData[31:1];
        end else if (wd_fire) begin
          state_d = S_TIMEOUT;
        end
      end
      S_PASS, S_FAIL, S_TIMEOUT: begin
        if (hostAck) state_d = S_ACKED;
      end
      S_ACKED: state_d = S_ACKED;
      default: state_d = S_RUN;
    endcase
  end

  // Host-facing outputs follow the state register, one cycle behind it.
  always_comb begin
    status_d = status_q;
    done_d   = 1'b0;
    halt_d   = (state_q != S_RUN);
    case (state_q)
      S_RUN:                     status_d = STAT_RUN;
      S_PASS, S_FAIL, S_TIMEOUT: begin
        status_d = state_to_status(state_q);
        done_d   = 1'b1;
      end
      default:                   status_d = status_q;
    endcase
  end

  // Registered read port: address at this edge, data after it.
  always_comb begin
    rd_data_d = '0;
    if (hit_tohost)
      rd_data_d = {fail_code_q, (status_q == STAT_PASS) || (status_q == STAT_FAIL)};
    else if (hit_cycle)
      rd_data_d = cycle_ext;
  end

  // All state and output registers; reset wins over everything.
  always_ff @(posedge sysClk) begin
    if (sysRes) begin
      state_q     <= S_RUN;
      fail_code_q <= '0;
      status_q    <= STAT_RUN;
      done_q      <= 1'b0;
      halt_q      <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      fail_code_q <= fail_code_d;
      status_q    <= status_d;
      done_q      <= done_d;
      halt_q      <= halt_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Sanity: a reported verdict always comes with the core halted, and a
  // halted core never still shows RUN.
  always_ff @(posedge sysClk) begin
    if (!sysRes) begin
      assert (!(done_q && !halt_q)) else $error("%s", MSG_DONE_NO_HALT);
      assert (!(halt_q && status_q == STAT_RUN)) else $error("%s", MSG_RUN_HALTED);
    end
  end

  assign busRdData = rd_data_q;
  assign cpuHalt   = halt_q;
  assign done      = done_q;
  assign status    = status_q;
  assign failCode  = fail_code_q;

endmodule
